// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32I decode / operand-read stage:
//   XLEN        - datapath width
//   OP_*        - major opcode encodings (instr[6:0])
//   instr_fmt_t - instruction format classification used by the decoder
// Optional feature macro used by this block: RF_BYPASS_EN (see rv_regfile).
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } instr_fmt_t;

endpackage

// File: rtl/rv_regfile.sv
// -----------------------------------------------------------------------------
// rv_regfile
// 2-read / 1-write register file with asynchronous reads.
//   clk, rst          - clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata  - write port; writes to address 0 are dropped
//   raddr1, raddr2    - read addresses
//   rdata1, rdata2    - read data; 0 for address 0 and while rst=0
// Build option RF_BYPASS_EN: a write in flight to a read address is forwarded
// to that read port in the same cycle. Without it, reads show stored values.
// -----------------------------------------------------------------------------
module rv_regfile
  import rv_pkg::*;
#(
  parameter int W     = XLEN,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  logic [W-1:0] regs_q [NREGS];
  logic [W-1:0] regs_d [NREGS];
  logic         wr_ok;

  // A write only lands when out of reset and not aimed at x0.
  assign wr_ok = rst && we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst) begin
`ifdef RF_BYPASS_EN
      rdata1 = (wr_ok && (waddr == raddr1)) ? wdata : regs_q[raddr1];
      rdata2 = (wr_ok && (waddr == raddr2)) ? wdata : regs_q[raddr2];
`else
      rdata1 = regs_q[raddr1];
      rdata2 = regs_q[raddr2];
`endif
      // x0 reads as zero regardless of storage contents.
      if (raddr1 == '0) rdata1 = '0;
      if (raddr2 == '0) rdata2 = '0;
    end
  end

endmodule

// File: rtl/rv_decode_regfile.sv
// -----------------------------------------------------------------------------
// rv_decode_regfile
// RV32I decode and operand-read stage. Splits instr into fields, classifies
// the format, builds the sign-extended immediate, and reads rs1/rs2 from an
// internal rv_regfile.
//   clk, rst                      - clock, synchronous active-low reset
//   instr                         - instruction being decoded
//   rf_write_en/_reg/_data        - register file write port (writeback)
//   rs1_read_data, rs2_read_data  - operands at instr[19:15], instr[24:20]
//   opcode, rd, funct3, funct7    - raw instruction fields
//   imm                           - sign-extended immediate (0 for R/illegal)
//   is_r..is_j, is_illegal        - one-hot format classification
//   is_add, is_sub, is_addi, is_load, is_store - instruction flags
// Build option RF_BYPASS_EN enables write-to-read forwarding in the regfile.
// All decode outputs are combinational from instr.
// -----------------------------------------------------------------------------
module rv_decode_regfile
  import rv_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            rf_write_en,
  input  logic [AW-1:0]   rf_write_reg,
  input  logic [XLEN-1:0] rf_write_data,
  output logic [XLEN-1:0] rs1_read_data,
  output logic [XLEN-1:0] rs2_read_data,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            is_r,
  output logic            is_i,
  output logic            is_s,
  output logic            is_b,
  output logic            is_u,
  output logic            is_j,
  output logic            is_illegal,
  output logic            is_add,
  output logic            is_sub,
  output logic            is_addi,
  output logic            is_load,
  output logic            is_store
);

  instr_fmt_t fmt;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    case (opcode)
      OP_R:                                   fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    fmt = FMT_I;
      OP_STORE:                               fmt = FMT_S;
      OP_BRANCH:                              fmt = FMT_B;
      OP_LUI, OP_AUIPC:                       fmt = FMT_U;
      OP_JAL:                                 fmt = FMT_J;
      default:                                fmt = FMT_ILL;
    endcase
  end

  assign is_r       = (fmt == FMT_R);
  assign is_i       = (fmt == FMT_I);
  assign is_s       = (fmt == FMT_S);
  assign is_b       = (fmt == FMT_B);
  assign is_u       = (fmt == FMT_U);
  assign is_j       = (fmt == FMT_J);
  assign is_illegal = (fmt == FMT_ILL);

  // Immediate scrambles; instr[31] is always the sign bit.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign is_add   = is_r && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = is_r && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi  = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // Source addresses come from fixed bit positions for every format.
  rv_regfile #(
    .W     (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_write_en),
    .waddr  (rf_write_reg),
    .wdata  (rf_write_data),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_read_data),
    .rdata2 (rs2_read_data)
  );

endmodule

// File: tb/tb_rv_decode_regfile.sv
module tb_rv_decode_regfile;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [31:0]     instr;
  logic            rf_write_en;
  logic [4:0]      rf_write_reg;
  logic [XLEN-1:0] rf_write_data;
  logic [XLEN-1:0] rs1_read_data, rs2_read_data;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic is_r, is_i, is_s, is_b, is_u, is_j, is_illegal;
  logic is_add, is_sub, is_addi, is_load, is_store;

  int n_checks = 0;
  int n_fail   = 0;

  rv_decode_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rs1_read_data (rs1_read_data),
    .rs2_read_data (rs2_read_data),
    .opcode        (opcode),
    .rd            (rd),
    .funct3        (funct3),
    .funct7        (funct7),
    .imm           (imm),
    .is_r          (is_r),
    .is_i          (is_i),
    .is_s          (is_s),
    .is_b          (is_b),
    .is_u          (is_u),
    .is_j          (is_j),
    .is_illegal    (is_illegal),
    .is_add        (is_add),
    .is_sub        (is_sub),
    .is_addi       (is_addi),
    .is_load       (is_load),
    .is_store      (is_store)
  );

  // {is_r,is_i,is_s,is_b,is_u,is_j,is_illegal}
  logic [6:0] fmt_vec;
  assign fmt_vec = {is_r, is_i, is_s, is_b, is_u, is_j, is_illegal};
  // {is_add,is_sub,is_addi,is_load,is_store}
  logic [4:0] flag_vec;
  assign flag_vec = {is_add, is_sub, is_addi, is_load, is_store};

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic en, input logic [4:0] r,
                             input logic [31:0] d);
    rf_write_en   = en;
    rf_write_reg  = r;
    rf_write_data = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst   = 1'b0;
    instr = 32'h0002_8033;           // add x0, x5, x0 (rs1=5)
    drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("reset_rs1_forced", rs1_read_data, 32'h0);
    tick();
    tick();
    check("reset_rs1_after_2_edges", rs1_read_data, 32'h0);

    // Leave reset; the write attempted during reset must not have landed.
    rst = 1'b1;
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    check("post_reset_x5_clear", rs1_read_data, 32'h0);

    // Write x5, read it back.
    drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    check("readback_x5", rs1_read_data, 32'hDEAD_BEEF);

    // Preload x0=10 (dropped) and x1=15.
    drive_write(1'b1, 5'd0, 32'd10);
    tick();
    drive_write(1'b1, 5'd1, 32'd15);
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    instr = 32'h0000_8033;           // add x0, x1, x0
    #1;
    check("add_fmt", {25'd0, fmt_vec}, {25'd0, 7'b1000000});
    check("add_flags", {27'd0, flag_vec}, {27'd0, 5'b10000});
    check("add_rs1", rs1_read_data, 32'd15);
    check("add_rs2_x0", rs2_read_data, 32'd0);
    check("add_rd", {27'd0, rd}, 32'd0);
    check("add_imm", imm, 32'd0);

    instr = 32'h4000_0033;           // sub x0, x0, x0
    #1;
    check("sub_flags", {27'd0, flag_vec}, {27'd0, 5'b01000});
    check("sub_funct7", {25'd0, funct7}, 32'h20);

    instr = 32'h0E30_0003;           // lb x0, 227(x0)
    #1;
    check("load_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0100000});
    check("load_flags", {27'd0, flag_vec}, {27'd0, 5'b00010});
    check("load_funct3", {29'd0, funct3}, 32'd0);
    check("load_imm", imm, 32'h0000_00E3);

    instr = 32'hFFF0_0013;           // addi x0, x0, -1
    #1;
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_flags", {27'd0, flag_vec}, {27'd0, 5'b00100});

    instr = 32'hFFDF_F06F;           // jal x0, -4
    #1;
    check("jal_imm", imm, 32'hFFFF_FFFC);
    check("jal_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0000010});

    instr = 32'hFE20_AC23;           // sw x2, -8(x1)
    #1;
    check("store_imm", imm, 32'hFFFF_FFF8);
    check("store_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0010000});
    check("store_flags", {27'd0, flag_vec}, {27'd0, 5'b00001});
    check("store_rs1_x1", rs1_read_data, 32'd15);

    instr = 32'h0000_0463;           // beq x0, x0, +8
    #1;
    check("branch_imm", imm, 32'd8);
    check("branch_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0001000});

    instr = 32'h1234_50B7;           // lui x1, 0x12345
    #1;
    check("lui_imm", imm, 32'h1234_5000);
    check("lui_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0000100});
    check("lui_rd", {27'd0, rd}, 32'd1);

    // Same-cycle write/read of x3 (old 0, new 7).
    instr = 32'h0031_8033;           // add x0, x3, x3
    drive_write(1'b1, 5'd3, 32'd7);
    #1;
`ifdef RF_BYPASS_EN
    check("x3_before_edge_rs1", rs1_read_data, 32'd7);
    check("x3_before_edge_rs2", rs2_read_data, 32'd7);
`else
    check("x3_before_edge_rs1", rs1_read_data, 32'd0);
    check("x3_before_edge_rs2", rs2_read_data, 32'd0);
`endif
    tick();
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    check("x3_after_edge_rs1", rs1_read_data, 32'd7);
    check("x3_after_edge_rs2", rs2_read_data, 32'd7);

    // Holding with write disabled keeps contents.
    tick();
    tick();
    check("x3_hold", rs1_read_data, 32'd7);

    // Reset beats a simultaneous write.
    rst = 1'b0;
    drive_write(1'b1, 5'd3, 32'd99);
    tick();
    rst = 1'b1;
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    check("midreset_x3_clear", rs1_read_data, 32'd0);
    instr = 32'h0000_8033;           // rs1 = x1
    #1;
    check("midreset_x1_clear", rs1_read_data, 32'd0);
    instr = 32'h0002_8033;           // rs1 = x5
    #1;
    check("midreset_x5_clear", rs1_read_data, 32'd0);

    // Illegal opcode.
    instr = 32'hFFFF_FFFF;
    #1;
    check("illegal_fmt", {25'd0, fmt_vec}, {25'd0, 7'b0000001});
    check("illegal_imm", imm, 32'd0);
    check("illegal_opcode", {25'd0, opcode}, 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
